// File: rtl/spi_cfg_pkg.sv
// Shared constants, FSM encoding and helpers for the SPI configuration master.
// Address map mirrors the register file of the SPI peripheral being configured.
package spi_cfg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
  localparam logic [6:0] ADDR_MAX         = 7'h04;

  localparam int   FRAME_BITS = 16;
  localparam logic WRITE_FLAG = 1'b1;
  localparam int   ENTRY_W    = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  function automatic logic addr_out_of_range(input logic [6:0] addr);
    return (addr > ADDR_MAX);
  endfunction

endpackage

// File: rtl/cfg_fifo.sv
// Small synchronous FIFO holding pending {addr, data} register writes.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cfg_fifo
  import spi_cfg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A push at full is legal only when the same cycle frees a slot.
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/spi_config_master.sv
// Write-only SPI mode-0 master: queues register writes and sends each as a
// 16-bit frame {write flag, addr, data}, MSB first, with a fixed nCS gap.
module spi_config_master
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS,
  output logic       busy,
  output logic       done,
  output logic       rej
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  // GAP is one cycle short of CS_GAP because the IDLE launch cycle also holds nCS high.
  localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 2);
  localparam logic [4:0] BITS_INIT = 5'(FRAME_BITS);

  state_e             state_q;
  logic [ENTRY_W-1:0] shift_q;
  logic [7:0]         phase_q;
  logic [4:0]         bit_cnt_q;
  logic               sclk_q;
  logic               copi_q;
  logic               ncs_q;
  logic               done_q;
  logic               rej_q;

  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [ENTRY_W-1:0] fifo_rdata_s;

  assign pop_s     = (state_q == ST_IDLE) && !fifo_empty_s;
  assign req_ready = !fifo_full_s || pop_s;
  assign accept_s  = req_valid && req_ready;
  assign push_s    = accept_s && !addr_out_of_range(req_addr);

  cfg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .wdata_i ({req_addr, req_data}),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Frame sequencer: launches, clocks out 16 bits and enforces the inter-frame gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      phase_q   <= 8'd0;
      bit_cnt_q <= 5'd0;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      ncs_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            shift_q   <= fifo_rdata_s;
            copi_q    <= WRITE_FLAG;
            ncs_q     <= 1'b0;
            phase_q   <= DIV_LAST;
            bit_cnt_q <= BITS_INIT;
            state_q   <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (phase_q == 8'd0) begin
            phase_q   <= DIV_LAST;
            sclk_q    <= 1'b1;
            bit_cnt_q <= bit_cnt_q - 5'd1;
            state_q   <= ST_HIGH;
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end
        ST_HIGH: begin
          if (phase_q == 8'd0) begin
            phase_q <= DIV_LAST;
            sclk_q  <= 1'b0;
            // Falling edge presents the next bit; the line parks low after the last one.
            copi_q  <= (bit_cnt_q == 5'd0) ? 1'b0 : shift_q[ENTRY_W-1];
            shift_q <= {shift_q[ENTRY_W-2:0], 1'b0};
            state_q <= ST_LOW;
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end
        ST_LOW: begin
          if (phase_q == 8'd0) begin
            if (bit_cnt_q != 5'd0) begin
              phase_q   <= DIV_LAST;
              sclk_q    <= 1'b1;
              bit_cnt_q <= bit_cnt_q - 5'd1;
              state_q   <= ST_HIGH;
            end else begin
              ncs_q   <= 1'b1;
              done_q  <= 1'b1;
              phase_q <= GAP_LAST;
              state_q <= ST_GAP;
            end
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end
        ST_GAP: begin
          if (phase_q == 8'd0) begin
            state_q <= ST_IDLE;
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sclk_q  <= 1'b0;
          copi_q  <= 1'b0;
          ncs_q   <= 1'b1;
        end
      endcase
    end
  end

  // Reject pulse for accepted writes outside the peripheral's register map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_q <= 1'b0;
    end else begin
      rej_q <= accept_s && addr_out_of_range(req_addr);
    end
  end

  assign SCLK = sclk_q;
  assign COPI = copi_q;
  assign nCS  = ncs_q;
  assign done = done_q;
  assign rej  = rej_q;
  assign busy = (state_q != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_spi_config_master.sv
// Randomised bench: a pin-level frame decoder plus a queue-based request model
// and a small register-file model of the SPI peripheral.
module tb_spi_config_master;

  localparam int CLK_DIV   = 4;
  localparam int CS_GAP    = 8;
  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 33 * CLK_DIV;
  localparam int PERIOD    = FRAME_LEN + CS_GAP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic [6:0] req_addr = 7'd0;
  logic [7:0] req_data = 8'd0;
  logic       req_ready, SCLK, COPI, nCS, busy, done, rej;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_config_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .SCLK(SCLK), .COPI(COPI),
    .nCS(nCS), .busy(busy), .done(done), .rej(rej)
  );

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          low;
    int          gap;
    logic        done_ok;
    logic        copi_end;
    int          glitch;
  } frame_t;

  frame_t      got_q[$];
  logic [15:0] exp_q[$];
  int          acc_cyc_q[$];
  int          exp_rej = 0;
  int          rej_cnt = 0;
  int          done_cnt = 0;
  logic [7:0]  regs [0:4];

  // Pin decoder / peripheral model state
  logic        m_prev_ncs = 1'b1, m_prev_sclk = 1'b0, m_prev_copi = 1'b0;
  logic        m_in = 1'b0, m_have_prev = 1'b0;
  logic [15:0] m_shift = 16'd0;
  int          m_nbits = 0, m_low = 0, m_high = 0, m_gap = -1, m_glitch = 0;
  frame_t      m_f;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_prev_ncs = 1'b1; m_prev_sclk = 1'b0; m_prev_copi = 1'b0;
      m_in = 1'b0; m_have_prev = 1'b0; m_nbits = 0; m_high = 0;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (rej === 1'b1) rej_cnt++;
      if (m_prev_ncs && !nCS) begin
        m_in = 1'b1; m_shift = 16'd0; m_nbits = 0; m_low = 0; m_glitch = 0;
        m_gap = m_have_prev ? m_high : -1;
      end
      if (!nCS) begin
        m_low++;
        if (!m_prev_sclk && SCLK) begin
          m_shift = {m_shift[14:0], COPI};
          m_nbits++;
          if (COPI !== m_prev_copi) m_glitch++;
        end
      end
      if (!m_prev_ncs && nCS && m_in) begin
        m_f.word = m_shift; m_f.nbits = m_nbits; m_f.low = m_low; m_f.gap = m_gap;
        m_f.done_ok = done; m_f.copi_end = COPI; m_f.glitch = m_glitch;
        got_q.push_back(m_f);
        if (m_nbits == 16 && m_shift[15] && m_shift[14:8] <= 7'h04)
          regs[m_shift[10:8]] = m_shift[7:0];
        m_in = 1'b0; m_have_prev = 1'b1; m_high = 1;
      end else if (nCS) begin
        m_high++;
      end
      m_prev_ncs = nCS; m_prev_sclk = SCLK; m_prev_copi = COPI;
    end
  end

  task automatic clear_model;
    got_q.delete(); exp_q.delete(); acc_cyc_q.delete();
    exp_rej = 0; rej_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 5; i++) regs[i] = 8'h00;
  endtask

  task automatic do_reset;
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    clear_model();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Present one request and hold it until accepted; updates the reference model.
  task automatic send(input logic [6:0] a, input logic [7:0] d);
    int w = 0;
    req_valid = 1'b1; req_addr = a; req_data = d;
    #1;
    while (!req_ready && w < 4000) begin @(negedge clk); #1; w++; end
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: req_ready=%b after %0d cycles, required 1", req_ready, w);
    end else begin
      acc_cyc_q.push_back(cyc);
      if (a <= 7'h04) exp_q.push_back({1'b1, a, d});
      else exp_rej++;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_quiet;
    int w = 0;
    while ((busy || !nCS) && w < 20000) begin @(negedge clk); w++; end
    if (busy || !nCS) begin
      n_cmp++; n_fail++;
      $display("FAIL quiet_timeout: busy=%b nCS=%b, required 0/1", busy, nCS);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({SCLK, COPI, nCS, done, rej, busy, req_ready} !== 7'b0010001) begin
      n_fail++;
      $display("FAIL reset_async: {sclk,copi,ncs,done,rej,busy,ready}=%b required 0010001",
               {SCLK, COPI, nCS, done, rej, busy, req_ready});
    end
    repeat (2) @(negedge clk);
    clear_model();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({SCLK, COPI, nCS, done, rej, busy, req_ready} !== 7'b0010001 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle: outputs=%b frames=%0d required 0010001 and 0 frames",
               {SCLK, COPI, nCS, done, rej, busy, req_ready}, got_q.size());
    end
  endtask

  task automatic test_single;
    int w = 0;
    do_reset();
    send(7'h04, 8'h80);
    n_cmp++;
    if ({nCS, busy} !== 2'b11) begin
      n_fail++; $display("FAIL single_launch: nCS,busy=%b required 11", {nCS, busy});
    end
    @(negedge clk);
    n_cmp++;
    if (nCS !== 1'b0) begin
      n_fail++; $display("FAIL single_accept_to_ncs: nCS=%b two cycles after accept, required 0", nCS);
    end
    while (done !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
    repeat (CS_GAP - 2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL single_busy_gap_end: busy=%b on last GAP cycle, required 1", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy_fall: busy=%b after GAP, required 0", busy);
    end
    wait_quiet();
    n_cmp++;
    if (got_q.size() != 1 || done_cnt != 1) begin
      n_fail++; $display("FAIL single_count: frames=%0d done=%0d required 1/1", got_q.size(), done_cnt);
    end else begin
      n_cmp++;
      if (got_q[0].word !== 16'h8480 || got_q[0].nbits != 16 || got_q[0].low != FRAME_LEN ||
          got_q[0].done_ok !== 1'b1 || got_q[0].copi_end !== 1'b0 || got_q[0].glitch != 0) begin
        n_fail++;
        $display("FAIL single_frame: word=%h bits=%0d low=%0d done=%b copi_end=%b glitch=%0d required 8480/16/%0d/1/0/0",
                 got_q[0].word, got_q[0].nbits, got_q[0].low, got_q[0].done_ok,
                 got_q[0].copi_end, got_q[0].glitch, FRAME_LEN);
      end
    end
  endtask

  task automatic test_reject;
    int low_seen = 0;
    do_reset();
    send(7'($urandom_range(5, 127)), 8'($urandom));
    n_cmp++;
    if ({rej, busy} !== 2'b10) begin
      n_fail++; $display("FAIL reject_pulse: rej,busy=%b next cycle, required 10", {rej, busy});
    end
    @(negedge clk);
    n_cmp++;
    if (rej !== 1'b0) begin
      n_fail++; $display("FAIL reject_width: rej=%b second cycle, required 0", rej);
    end
    repeat (30) begin @(negedge clk); if (!nCS || busy) low_seen++; end
    n_cmp++;
    if (low_seen != 0 || got_q.size() != 0 || rej_cnt != 1) begin
      n_fail++;
      $display("FAIL reject_no_frame: active=%0d frames=%0d rej=%0d required 0/0/1", low_seen, got_q.size(), rej_cnt);
    end
  endtask

  task automatic test_burst;
    do_reset();
    for (int i = 0; i < 6; i++) send(7'($urandom_range(0, 4)), 8'($urandom));
    for (int i = 1; i < 6; i++) begin
      n_cmp++;
      if (acc_cyc_q[i] - acc_cyc_q[0] != ((i < 5) ? i : 1 + PERIOD)) begin
        n_fail++;
        $display("FAIL burst_accept[%0d]: accepted %0d cycles after first, required %0d",
                 i, acc_cyc_q[i] - acc_cyc_q[0], (i < 5) ? i : 1 + PERIOD);
      end
    end
    wait_quiet();
    n_cmp++;
    if (got_q.size() != 6 || done_cnt != 6) begin
      n_fail++; $display("FAIL burst_count: frames=%0d done=%0d required 6/6", got_q.size(), done_cnt);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      frame_t f = got_q[i];
      n_cmp++;
      if (f.word !== exp_q[i] || f.nbits != 16 || f.low != FRAME_LEN || f.done_ok !== 1'b1 ||
          f.copi_end !== 1'b0 || f.glitch != 0 || (i > 0 && f.gap != CS_GAP)) begin
        n_fail++;
        $display("FAIL burst_frame[%0d]: word=%h bits=%0d low=%0d gap=%0d done=%b glitch=%0d required %h/16/%0d/%0d/1/0",
                 i, f.word, f.nbits, f.low, f.gap, f.done_ok, f.glitch, exp_q[i], FRAME_LEN, CS_GAP);
      end
    end
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      repeat ((i % 9 == 8) ? $urandom_range(100, 250) : $urandom_range(0, 3)) @(negedge clk);
      send(7'($urandom_range(0, 7)), 8'($urandom));
    end
    wait_quiet();
    n_cmp++;
    if (got_q.size() != exp_q.size() || done_cnt != exp_q.size() || rej_cnt != exp_rej) begin
      n_fail++;
      $display("FAIL random_count: frames=%0d done=%0d rej=%0d required %0d/%0d/%0d",
               got_q.size(), done_cnt, rej_cnt, exp_q.size(), exp_q.size(), exp_rej);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      frame_t f = got_q[i];
      n_cmp++;
      if (f.word !== exp_q[i] || f.nbits != 16 || f.low != FRAME_LEN || f.done_ok !== 1'b1 ||
          f.copi_end !== 1'b0 || f.glitch != 0 || (i > 0 && f.gap < CS_GAP)) begin
        n_fail++;
        $display("FAIL random_frame[%0d]: word=%h bits=%0d low=%0d gap=%0d done=%b glitch=%0d required %h/16/%0d/>=%0d/1/0",
                 i, f.word, f.nbits, f.low, f.gap, f.done_ok, f.glitch, exp_q[i], FRAME_LEN, CS_GAP);
      end
    end
  endtask

  task automatic test_reset_mid;
    int w = 0;
    int low_seen = 0;
    do_reset();
    for (int i = 0; i < 3; i++) send(7'($urandom_range(0, 4)), 8'($urandom));
    while (m_nbits != 7 && w < 1000) begin @(negedge clk); w++; end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({SCLK, COPI, nCS, busy, req_ready} !== 5'b00101 || w >= 1000) begin
      n_fail++;
      $display("FAIL reset_mid: sclk,copi,ncs,busy,ready=%b wait=%0d required 00101",
               {SCLK, COPI, nCS, busy, req_ready}, w);
    end
    repeat (2) @(negedge clk);
    got_q.delete(); exp_q.delete(); done_cnt = 0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_busy: busy=%b after release, required 0", busy);
    end
    repeat (300) begin @(negedge clk); if (!nCS) low_seen++; end
    n_cmp++;
    if (low_seen != 0 || got_q.size() != 0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_mid_flush: ncs_low=%0d frames=%0d done=%0d required 0/0/0", low_seen, got_q.size(), done_cnt);
    end
  endtask

  task automatic test_end_to_end;
    logic [7:0] want;
    do_reset();
    send(7'h00, 8'hA5);
    send(7'h04, 8'h40);
    wait_quiet();
    for (int a = 0; a < 5; a++) begin
      want = (a == 0) ? 8'hA5 : ((a == 4) ? 8'h40 : 8'h00);
      n_cmp++;
      if (regs[a] !== want) begin
        n_fail++; $display("FAIL e2e_reg[%0d]: value=%h required %h", a, regs[a], want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reject();
    test_burst();
    test_random();
    test_reset_mid();
    test_end_to_end();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
